washer_ctrl_p: RTL and testbench

- Parametrised next-generation washing-machine controller with a single clock and a 1 Hz tick enable.
- Sequences fill → N × (pause, forward, pause, reverse) → drain → done.
- Drives the motor (zheng/fan), valves (inlet/drain), LEDs, alarm and state/timer visibility.
- Adds water-level handshakes, fill/drain timeouts with fault, a safe emergency stop with forced drain, and edge-detected buttons.

---
 rtl/washer_ctrl_p.sv | 158 +++++++++++++++
 tb/tb_washer_ctrl_p.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/washer_ctrl_p.sv
// Washing-machine sequencer: fill, N x (pause/fwd/pause/rev), drain, done, with fault and e-stop handling.
// Outputs decode only the registered state. Button inputs are edge-detected, so a held button produces one event.
module washer_ctrl_p #(
    parameter int CNT_W       = 7,
    parameter int CYC_W       = 4,
    parameter int MAX_CYC     = 15,
    parameter int DEF_CYC     = 1,
    parameter int T_PAUSE     = 5,
    parameter int T_RUN       = 60,
    parameter int T_FILL_MAX  = 90,
    parameter int T_DRAIN_MAX = 90
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             add,
    input  logic             start,
    input  logic             emergency,
    input  logic             water_full,
    input  logic             water_empty,
    output logic             zheng,
    output logic             fan,
    output logic             inlet,
    output logic             drain,
    output logic             ledzheng,
    output logic             ledfan,
    output logic             ledstop,
    output logic             alarm,
    output logic [3:0]       mode,
    output logic [CNT_W-1:0] count,
    output logic [CYC_W-1:0] cyc_left
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FILL    = 4'd1,
        S_PAUSE_A = 4'd2,
        S_FWD     = 4'd3,
        S_PAUSE_B = 4'd4,
        S_REV     = 4'd5,
        S_DRAIN   = 4'd6,
        S_DONE    = 4'd7,
        S_FAULT   = 4'd8,
        S_ESTOP   = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] L_PAUSE_END = CNT_W'(T_PAUSE - 1);
    localparam logic [CNT_W-1:0] L_RUN_END   = CNT_W'(T_RUN - 1);
    localparam logic [CNT_W-1:0] L_FILL_END  = CNT_W'(T_FILL_MAX - 1);
    localparam logic [CNT_W-1:0] L_DRAIN_END = CNT_W'(T_DRAIN_MAX - 1);
    localparam logic [CYC_W-1:0] L_CYC_MAX   = CYC_W'(MAX_CYC);
    localparam logic [CYC_W-1:0] L_CYC_DEF   = CYC_W'(DEF_CYC);
    localparam logic [CYC_W-1:0] L_CYC_ONE   = CYC_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic [CYC_W-1:0] r_cyc_set;
    logic [CYC_W-1:0] r_cyc_left;
    logic [CYC_W-1:0] w_cyc_set_nxt;
    logic [CYC_W-1:0] w_cyc_left_nxt;
    logic             r_add_d;
    logic             r_start_d;
    logic             w_add_edge;
    logic             w_start_edge;
    logic             w_pause_done;
    logic             w_run_done;

    assign w_add_edge   = add & ~r_add_d;
    assign w_start_edge = start & ~r_start_d;
    assign w_pause_done = tick && (r_count == L_PAUSE_END);
    assign w_run_done   = tick && (r_count == L_RUN_END);

    always_comb begin
        w_next         = r_state;
        w_cyc_set_nxt  = r_cyc_set;
        w_cyc_left_nxt = r_cyc_left;
        if (!emergency && (r_state != S_IDLE)) begin
            w_next = S_ESTOP;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_add_edge && (r_cyc_set < L_CYC_MAX))
                        w_cyc_set_nxt = r_cyc_set + 1'b1;
                    // An e-stop held in IDLE swallows the start edge.
                    if (w_start_edge && emergency && (r_cyc_set != '0)) begin
                        w_cyc_left_nxt = r_cyc_set;
                        w_next         = S_FILL;
                    end
                end
                S_FILL: begin
                    if (tick && (r_count == L_FILL_END)) w_next = S_FAULT;
                    else if (water_full)                 w_next = S_PAUSE_A;
                end
                S_PAUSE_A: if (w_pause_done) w_next = S_FWD;
                S_FWD:     if (w_run_done)   w_next = S_PAUSE_B;
                S_PAUSE_B: if (w_pause_done) w_next = S_REV;
                S_REV: begin
                    if (w_run_done) begin
                        if (r_cyc_left <= L_CYC_ONE) begin
                            w_cyc_left_nxt = '0;
                            w_next         = S_DRAIN;
                        end else begin
                            w_cyc_left_nxt = r_cyc_left - 1'b1;
                            w_next         = S_PAUSE_A;
                        end
                    end
                end
                S_DRAIN: begin
                    if (tick && (r_count == L_DRAIN_END)) w_next = S_FAULT;
                    else if (water_empty)                 w_next = S_DONE;
                end
                S_DONE, S_FAULT: if (w_start_edge) w_next = S_IDLE;
                S_ESTOP: begin
                    if (water_empty) begin
                        w_cyc_left_nxt = '0;
                        w_next         = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_cyc_set  <= L_CYC_DEF;
            r_cyc_left <= '0;
            r_add_d    <= 1'b0;
            r_start_d  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cyc_set  <= w_cyc_set_nxt;
            r_cyc_left <= w_cyc_left_nxt;
            r_add_d    <= add;
            r_start_d  <= start;
            if (w_next != r_state)
                r_count <= '0;
            else if (tick && (r_count != '1))
                r_count <= r_count + 1'b1;
        end
    end

    assign zheng    = (r_state == S_FWD);
    assign fan      = (r_state == S_REV);
    assign ledzheng = zheng;
    assign ledfan   = fan;
    assign ledstop  = ~(zheng | fan);
    assign inlet    = (r_state == S_FILL);
    assign drain    = (r_state == S_DRAIN) || (r_state == S_ESTOP);
    assign alarm    = (r_state == S_DONE) || (r_state == S_FAULT) || (r_state == S_ESTOP);
    assign mode     = r_state;
    assign count    = r_count;
    assign cyc_left = r_cyc_left;

endmodule

// File: tb/tb_washer_ctrl_p.sv
// Directed bench for washer_ctrl_p; a second instance with DEF_CYC=0 covers the empty-program start.
module tb_washer_ctrl_p;

    logic clk = 1'b0;
    logic rst, tick, add, start, emergency, water_full, water_empty;
    logic zheng, fan, inlet, drain, ledzheng, ledfan, ledstop, alarm;
    logic [3:0] mode;
    logic [6:0] count;
    logic [3:0] cyc_left;
    logic zheng0, fan0, inlet0, drain0, ledzheng0, ledfan0, ledstop0, alarm0;
    logic [3:0] mode0;
    logic [6:0] count0;
    logic [3:0] cyc_left0;
    logic add0 = 1'b0;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // {zheng, fan, ledzheng, ledfan, ledstop, inlet, drain, alarm}
    assign outs = {zheng, fan, ledzheng, ledfan, ledstop, inlet, drain, alarm};

    washer_ctrl_p dut (
        .clk(clk), .rst(rst), .tick(tick), .add(add), .start(start),
        .emergency(emergency), .water_full(water_full), .water_empty(water_empty),
        .zheng(zheng), .fan(fan), .inlet(inlet), .drain(drain),
        .ledzheng(ledzheng), .ledfan(ledfan), .ledstop(ledstop), .alarm(alarm),
        .mode(mode), .count(count), .cyc_left(cyc_left)
    );

    washer_ctrl_p #(.DEF_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .add(add0), .start(start),
        .emergency(emergency), .water_full(water_full), .water_empty(water_empty),
        .zheng(zheng0), .fan(fan0), .inlet(inlet0), .drain(drain0),
        .ledzheng(ledzheng0), .ledfan(ledfan0), .ledstop(ledstop0), .alarm(alarm0),
        .mode(mode0), .count(count0), .cyc_left(cyc_left0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            clks(1);
            tick = 1'b0;
            clks(1);
        end
    endtask

    task automatic press_add;
        add = 1'b1;
        clks(2);
        add = 1'b0;
        clks(2);
    endtask

    task automatic press_start;
        start = 1'b1;
        clks(2);
        start = 1'b0;
        clks(2);
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; add = 1'b0; start = 1'b0;
        emergency = 1'b1; water_full = 1'b0; water_empty = 1'b0;
        clks(3);
        check("rst_outs", outs, 8'h08);
        check("rst_mode", mode, 0);
        check("rst_count", count, 0);
        check("rst_cyc_left", cyc_left, 0);
        rst = 1'b1;
        clks(2);

        // Three adds on top of DEF_CYC=1, then launch.
        repeat (3) press_add();
        press_start();
        check("launch_mode", mode, 1);
        check("launch_cyc_left", cyc_left, 4);
        check("launch_outs", outs, 8'h0C);
        check("zero_cyc_start_ignored", mode0, 0);

        ticks(3);
        check("fill_count3", count, 3);
        water_full = 1'b1;
        clks(1);
        water_full = 1'b0;
        check("fill_to_pause_mode", mode, 2);
        check("pause_entry_count", count, 0);
        ticks(4);
        check("pause_a_4ticks", mode, 2);
        ticks(1);
        check("pause_a_to_fwd", mode, 3);
        check("fwd_outs", outs, 8'hA0);

        ticks(30);
        check("fwd_count30", count, 30);
        emergency = 1'b0;
        clks(1);
        check("estop_mode", mode, 9);
        check("estop_outs", outs, 8'h0B);
        emergency = 1'b1;
        ticks(2);
        clks(3);
        check("estop_hold_not_empty", mode, 9);
        water_empty = 1'b1;
        clks(1);
        check("estop_exit_mode", mode, 0);
        check("estop_exit_cyc_left", cyc_left, 0);
        water_empty = 1'b0;
        clks(1);

        // Held start: one launch only; back in IDLE it must not relaunch.
        start = 1'b1;
        clks(200);
        check("held_start_mode", mode, 1);
        check("held_start_cyc_left", cyc_left, 4);
        check("held_start_dut0", mode0, 0);
        emergency = 1'b0;
        clks(1);
        emergency = 1'b1;
        water_empty = 1'b1;
        clks(1);
        check("held_start_back_idle", mode, 0);
        clks(20);
        check("held_start_no_relaunch", mode, 0);
        start = 1'b0;
        water_empty = 1'b0;
        clks(2);
        emergency = 1'b0;
        press_start();
        check("start_during_estop_ignored", mode, 0);
        emergency = 1'b1;
        clks(2);

        // Fill timeout.
        press_start();
        check("timeout_fill_mode", mode, 1);
        ticks(89);
        check("timeout_89_still_fill", mode, 1);
        check("timeout_count89", count, 89);
        ticks(1);
        check("timeout_fault_mode", mode, 8);
        check("timeout_fault_outs", outs, 8'h09);
        press_start();
        check("fault_start_idle", mode, 0);

        repeat (20) press_add();
        press_start();
        check("cyc_set_saturates", cyc_left, 15);

        // Reach REV, then reset coincident with a tick.
        water_full = 1'b1;
        clks(1);
        water_full = 1'b0;
        ticks(5);
        ticks(60);
        check("pause_b_mode", mode, 4);
        ticks(5);
        check("rev_mode", mode, 5);
        check("rev_outs", outs, 8'h50);
        ticks(10);
        rst = 1'b0;
        tick = 1'b1;
        clks(1);
        check("midrev_rst_outs", outs, 8'h08);
        check("midrev_rst_mode", mode, 0);
        check("midrev_rst_count", count, 0);
        check("midrev_rst_cyc_left", cyc_left, 0);
        tick = 1'b0;
        rst = 1'b1;
        clks(2);

        // Full single-cycle program with DEF_CYC restored.
        press_start();
        check("def_cyc_restored", cyc_left, 1);
        ticks(3);
        water_full = 1'b1;
        clks(1);
        water_full = 1'b0;
        check("prog_pause_a", mode, 2);
        ticks(5);
        check("prog_fwd", mode, 3);
        ticks(59);
        check("prog_fwd_59", outs, 8'hA0);
        ticks(1);
        check("prog_pause_b", mode, 4);
        check("prog_pause_b_outs", outs, 8'h08);
        ticks(4);
        check("prog_pause_b_4", mode, 4);
        ticks(1);
        check("prog_rev", mode, 5);
        ticks(59);
        check("prog_rev_59", mode, 5);
        ticks(1);
        check("prog_drain_mode", mode, 6);
        check("prog_drain_outs", outs, 8'h0A);
        check("prog_drain_cyc_left", cyc_left, 0);
        ticks(1);
        check("prog_drain_wait", mode, 6);
        water_empty = 1'b1;
        clks(1);
        water_empty = 1'b0;
        check("prog_done_mode", mode, 7);
        check("prog_done_outs", outs, 8'h09);
        press_start();
        check("done_start_idle", mode, 0);
        check("idle_outs", outs, 8'h08);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
